// File: rtl/box_if.sv
// box_if: valid/ready channel that carries box descriptors from the inference side.
interface box_if #(parameter int COORD_W = 10);
    logic               box_valid;
    logic               box_ready;
    logic [COORD_W-1:0] box_x0;
    logic [COORD_W-1:0] box_y0;
    logic [COORD_W-1:0] box_x1;
    logic [COORD_W-1:0] box_y1;
    logic [23:0]        box_color;
    logic               box_last;
    modport master (output box_valid, box_x0, box_y0, box_x1, box_y1, box_color, box_last, input box_ready);
    modport slave  (input box_valid, box_x0, box_y0, box_x1, box_y1, box_color, box_last, output box_ready);
endinterface

// File: rtl/box_overlay.sv
// box_overlay: draws rectangle outlines over the video stream with a fixed 2-cycle latency.
// Defining BOX_FILL_EN also half-blends the interior of the lowest covering box.
module box_overlay #(
    parameter int MAX_BOXES = 8,
    parameter int THICK     = 2,
    parameter int COORD_W   = 10
) (
    input  logic               clk,
    input  logic               reset,
    box_if.slave               bx,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic               vde,
    input  logic               hsync,
    input  logic               vsync,
    input  logic [7:0]         base_red,
    input  logic [7:0]         base_green,
    input  logic [7:0]         base_blue,
    output logic [7:0]         red,
    output logic [7:0]         green,
    output logic [7:0]         blue,
    output logic               hsync_o,
    output logic               vsync_o,
    output logic               vde_o,
    output logic [4:0]         active_count,
    output logic [7:0]         bad_count
);
    localparam int IW = MAX_BOXES > 1 ? $clog2(MAX_BOXES) : 1;
    typedef logic [COORD_W:0] cw_t;
    typedef enum logic [1:0] {FILL, FULL, WAIT} state_t;
    typedef struct packed {
        logic [COORD_W-1:0] x0, y0, x1, y1;
        logic [23:0]        col;
    } box_t;
    state_t               state, state_n;
    box_t                 shd [MAX_BOXES];
    box_t                 act [MAX_BOXES];
    logic [4:0]           ptr;
    logic                 xfer, bad, wr, swap;
    logic [MAX_BOXES-1:0] ins, edg, edg_q;
    logic [23:0]          base1, edge_col, pick;
    logic                 hs1, vs1, de1, hit;
`ifdef BOX_FILL_EN
    logic [MAX_BOXES-1:0] ins_q;
    logic [23:0]          in_col, blend;
    logic                 in_hit;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= FILL;
        else        state <= state_n;
    end

    // vs1 doubles as the registered vsync for the frame-boundary edge detect
    always_comb begin
        bx.box_ready = reset && state != WAIT;
        xfer    = bx.box_valid && bx.box_ready;
        bad     = bx.box_x0 > bx.box_x1 || bx.box_y0 > bx.box_y1;
        wr      = xfer && state == FILL && !bad;
        swap    = state == WAIT && vsync && !vs1;
        state_n = (xfer && bx.box_last) ? WAIT :
                  (wr && ptr == 5'(MAX_BOXES - 1)) ? FULL :
                  swap ? FILL : state;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr          <= '0;
            active_count <= '0;
            bad_count    <= '0;
        end else begin
            if (xfer && (bad || state == FULL) && bad_count != 8'hFF) bad_count <= bad_count + 8'd1;
            ptr <= swap ? '0 : ptr + 5'(wr);
            if (swap) active_count <= ptr;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < MAX_BOXES; i++) begin
                shd[i] <= '0;
                act[i] <= '0;
            end
        end else begin
            if (wr) shd[ptr[IW-1:0]] <= '{bx.box_x0, bx.box_y0, bx.box_x1, bx.box_y1, bx.box_color};
            if (swap) act <= shd;
        end
    end

    // one extra bit on the sums keeps boxes touching the last column/row from wrapping
    always_comb begin
        ins = '0;
        edg = '0;
        for (int i = 0; i < MAX_BOXES; i++) begin
            ins[i] = 5'(i) < active_count && x >= act[i].x0 && x <= act[i].x1 &&
                     y >= act[i].y0 && y <= act[i].y1;
            edg[i] = ins[i] && ({1'b0, x} < {1'b0, act[i].x0} + cw_t'(THICK) ||
                                {1'b0, x} + cw_t'(THICK) > {1'b0, act[i].x1} ||
                                {1'b0, y} < {1'b0, act[i].y0} + cw_t'(THICK) ||
                                {1'b0, y} + cw_t'(THICK) > {1'b0, act[i].y1});
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            edg_q <= '0;
            base1 <= '0;
            hs1   <= 1'b0;
            vs1   <= 1'b0;
            de1   <= 1'b0;
        end else begin
            edg_q <= edg;
            base1 <= {base_red, base_green, base_blue};
            hs1   <= hsync;
            vs1   <= vsync;
            de1   <= vde;
        end
    end

`ifdef BOX_FILL_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ins_q <= '0;
        else        ins_q <= ins;
    end
`endif

    // descending scans so the lowest index is the last one written
    always_comb begin
        hit      = 1'b0;
        edge_col = '0;
        for (int i = MAX_BOXES - 1; i >= 0; i--) begin
            if (edg_q[i]) begin
                hit      = 1'b1;
                edge_col = act[i].col;
            end
        end
`ifdef BOX_FILL_EN
        in_hit = 1'b0;
        in_col = '0;
        for (int i = MAX_BOXES - 1; i >= 0; i--) begin
            if (ins_q[i]) begin
                in_hit = 1'b1;
                in_col = act[i].col;
            end
        end
        blend = '0;
        for (int c = 0; c < 3; c++)
            blend[8*c +: 8] = 8'((9'(base1[8*c +: 8]) + 9'(in_col[8*c +: 8])) >> 1);
        pick = hit ? edge_col : in_hit ? blend : base1;
`else
        pick = hit ? edge_col : base1;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            {red, green, blue} <= '0;
            hsync_o            <= 1'b0;
            vsync_o            <= 1'b0;
            vde_o              <= 1'b0;
        end else begin
            {red, green, blue} <= de1 ? pick : 24'h0;
            hsync_o            <= hs1;
            vsync_o            <= vs1;
            vde_o              <= de1;
        end
    end
endmodule

// File: tb/tb_box_overlay.sv
// tb_box_overlay: vector table, hand sequences and a random pixel stream against a box-list model.
module tb_box_overlay;
    localparam int MAXB = 8, TH = 2, CW = 10;
    localparam logic [23:0] BASE = 24'h405060, RED = 24'hFF0000;

    logic          clk = 0, reset = 0;
    logic [CW-1:0] x = '0, y = '0;
    logic          vde = 0, hsync = 0, vsync = 0;
    logic [7:0]    br = 0, bg = 0, bb = 0;
    logic [7:0]    red, green, blue;
    logic          hsync_o, vsync_o, vde_o;
    logic [4:0]    active_count;
    logic [7:0]    bad_count;

    box_if #(.COORD_W(CW)) bx();

    box_overlay #(.MAX_BOXES(MAXB), .THICK(TH), .COORD_W(CW)) dut (
        .clk(clk), .reset(reset), .bx(bx),
        .x(x), .y(y), .vde(vde), .hsync(hsync), .vsync(vsync),
        .base_red(br), .base_green(bg), .base_blue(bb),
        .red(red), .green(green), .blue(blue),
        .hsync_o(hsync_o), .vsync_o(vsync_o), .vde_o(vde_o),
        .active_count(active_count), .bad_count(bad_count)
    );

    always #5 clk = ~clk;

    typedef struct {int x0, y0, x1, y1; logic [23:0] col;} mbox_t;
    typedef struct {int px, py; logic [23:0] base; logic de; logic [23:0] exp;} vec_t;
    typedef struct {logic [23:0] c; logic hs, vs, de;} exp_t;

    mbox_t shadow[$], active[$];
    int    exp_bad = 0;
    bit    committed = 0;
    int    tests = 0, fails = 0;

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic bit covers(mbox_t b, int px, int py);
        return px >= b.x0 && px <= b.x1 && py >= b.y0 && py <= b.y1;
    endfunction

    // a pixel is on the outline when its distance to the nearest side is below the thickness
    function automatic int side_dist(mbox_t b, int px, int py);
        int d = px - b.x0;
        if (b.x1 - px < d) d = b.x1 - px;
        if (py - b.y0 < d) d = py - b.y0;
        if (b.y1 - py < d) d = b.y1 - py;
        return d;
    endfunction

    function automatic logic [23:0] model_px(int px, int py, logic [23:0] base, logic de);
        if (!de) return 24'h0;
        foreach (active[i])
            if (covers(active[i], px, py) && side_dist(active[i], px, py) < TH) return active[i].col;
`ifdef BOX_FILL_EN
        foreach (active[i]) begin
            if (covers(active[i], px, py)) begin
                logic [23:0] r;
                for (int c = 0; c < 3; c++)
                    r[8*c +: 8] = 8'((int'(base[8*c +: 8]) + int'(active[i].col[8*c +: 8])) / 2);
                return r;
            end
        end
`endif
        return base;
    endfunction

    task automatic mxfer(int x0, int y0, int x1, int y1, logic [23:0] col, bit last);
        if (x0 > x1 || y0 > y1 || shadow.size() == MAXB) exp_bad = exp_bad < 255 ? exp_bad + 1 : 255;
        else shadow.push_back('{x0, y0, x1, y1, col});
        if (last) committed = 1;
    endtask

    task automatic drive_box(int x0, int y0, int x1, int y1, logic [23:0] col, bit last);
        bx.box_valid = 1;
        bx.box_x0 = CW'(x0); bx.box_y0 = CW'(y0);
        bx.box_x1 = CW'(x1); bx.box_y1 = CW'(y1);
        bx.box_color = col;  bx.box_last = last;
    endtask

    task automatic send(int x0, int y0, int x1, int y1, logic [23:0] col, bit last);
        int n = 0;
        @(negedge clk);
        drive_box(x0, y0, x1, y1, col, last);
        while (!bx.box_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bx.box_ready) check("send_timeout", 0, 1);
        else begin
            @(posedge clk);
            mxfer(x0, y0, x1, y1, col, last);
        end
        #1 bx.box_valid = 0;
    endtask

    task automatic vpulse();
        @(negedge clk);
        vsync = 1;
        @(posedge clk);
        if (committed) begin
            active = shadow;
            shadow.delete();
            committed = 0;
        end
        @(negedge clk);
        vsync = 0;
        @(negedge clk);
    endtask

    task automatic pix(string nm, int px, int py, logic [23:0] base, logic de, logic [23:0] exp);
        @(negedge clk);
        x = CW'(px); y = CW'(py); {br, bg, bb} = base; vde = de;
        repeat (2) @(negedge clk);
        check(nm, {8'h0, red, green, blue}, {8'h0, exp});
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t  vecs[10];
        exp_t  q[$], e;
        mbox_t rb;
        vecs[0] = '{10, 25, BASE, 1'b1, RED};
        vecs[1] = '{11, 25, BASE, 1'b1, RED};
        vecs[2] = '{12, 25, BASE, 1'b1, BASE};
        vecs[3] = '{13, 25, BASE, 1'b1, BASE};
        vecs[4] = '{49, 25, BASE, 1'b1, RED};
        vecs[5] = '{9,  25, BASE, 1'b1, BASE};
        vecs[6] = '{30, 10, BASE, 1'b1, RED};
        vecs[7] = '{30, 40, BASE, 1'b1, RED};
        vecs[8] = '{51, 25, BASE, 1'b1, BASE};
        vecs[9] = '{10, 25, BASE, 1'b0, 24'h0};
        bx.box_valid = 0; drive_box(0, 0, 0, 0, 0, 0); bx.box_valid = 0;

        repeat (3) @(negedge clk);
        check("rst_rgb", {8'h0, red, green, blue}, 0);
        check("rst_ready", 32'(bx.box_ready), 0);
        reset = 1;
        @(negedge clk);
        check("ready_after_rst", 32'(bx.box_ready), 1);
        check("cnt_after_rst", {active_count, bad_count}, 0);

        x = 5; y = 5; {br, bg, bb} = 24'h102030; vde = 1; hsync = 1;
        @(negedge clk);
        check("lat_1cyc", {7'h0, hsync_o, red, green, blue}, 0);
        @(negedge clk);
        check("lat_2cyc", {5'h0, hsync_o, vsync_o, vde_o, red, green, blue}, {5'h0, 3'b101, 24'h102030});
        hsync = 0;

        send(10, 10, 50, 40, RED, 1);
        check("wait_ready", 32'(bx.box_ready), 0);
        check("no_swap_yet", 32'(active_count), 0);
        vpulse();
        check("one_box", 32'(active_count), 1);
        foreach (vecs[i]) pix($sformatf("vec%0d", i), vecs[i].px, vecs[i].py, vecs[i].base, vecs[i].de, vecs[i].exp);

        send(30, 30, 20, 60, RED, 1);
        check("bad_box", 32'(bad_count), 1);
        vpulse();
        check("bad_box_cnt", 32'(active_count), 0);
        pix("cleared", 10, 25, BASE, 1, BASE);

        rb = '{1000, 1000, 1023, 1023, 24'h00FFFF};
        send(rb.x0, rb.y0, rb.x1, rb.y1, rb.col, 0);
        for (int i = 1; i < MAXB; i++) begin
            int x0 = $urandom_range(0, 200), y0 = $urandom_range(0, 200);
            send(x0, y0, x0 + $urandom_range(0, 60), y0 + $urandom_range(0, 60),
                 24'($urandom_range(1, 24'hFFFFFF)), 0);
        end
        @(negedge clk);
        check("full_ready", 32'(bx.box_ready), 1);
        send(5, 5, 6, 6, 24'h123456, 1);
        check("full_bad", 32'(bad_count), 32'(exp_bad));
        repeat (3) @(negedge clk);
        check("full_wait_ready", 32'(bx.box_ready), 0);
        vpulse();
        check("full_cnt", 32'(active_count), 32'(active.size()));
        check("full_ready_back", 32'(bx.box_ready), 1);

        for (int n = 0; n < 400; n++) begin
            int px, py;
            @(negedge clk);
            if (q.size() == 2) begin
                e = q.pop_front();
                check("rand_px", {5'h0, hsync_o, vsync_o, vde_o, red, green, blue}, {5'h0, e.hs, e.vs, e.de, e.c});
            end
            px = ($urandom & 1) ? $urandom_range(990, 1023) : $urandom_range(0, 270);
            py = px >= 990 ? $urandom_range(990, 1023) : $urandom_range(0, 270);
            x = CW'(px); y = CW'(py);
            {br, bg, bb} = 24'($urandom);
            vde = ($urandom_range(0, 7) != 0);
            hsync = 1'($urandom); vsync = 1'($urandom);
            q.push_back('{model_px(px, py, {br, bg, bb}, vde), hsync, vsync, vde});
        end
        @(negedge clk);
        vsync = 0; hsync = 0;
        @(negedge clk);

        drive_box(5, 5, 20, 20, 24'hABCDEF, 1);
        vsync = 1;
        @(posedge clk);
        mxfer(5, 5, 20, 20, 24'hABCDEF, 1);
        #1 bx.box_valid = 0;
        @(negedge clk);
        check("commit_vs_same", 32'(active_count), MAXB);
        vsync = 0;
        vpulse();
        check("commit_next_vs", 32'(active_count), 1);
        pix("commit_px", 5, 12, BASE, 1, model_px(5, 12, BASE, 1));

        send(0, 0, 100, 100, 24'h0000FF, 0);
        send(0, 0, 100, 100, 24'h00FF00, 1);
        vpulse();
        pix("overlap_edge", 0, 0, 24'h808080, 1, 24'h0000FF);
        pix("overlap_right", 100, 50, 24'h808080, 1, 24'h0000FF);
`ifdef BOX_FILL_EN
        pix("overlap_fill", 50, 50, 24'h000000, 1, 24'h00007F);
`else
        pix("overlap_inner", 50, 50, 24'h000000, 1, 24'h000000);
`endif
        pix("overlap_model", 60, 40, 24'h123456, 1, model_px(60, 40, 24'h123456, 1));

        @(negedge clk);
        x = 0; y = 0; {br, bg, bb} = 24'h112233; vde = 1; hsync = 1;
        repeat (3) @(negedge clk);
        check("pre_reset_px", {8'h0, red, green, blue}, 24'h0000FF);
        #2 reset = 0;
        #1;
        check("async_rst_out", {5'h0, hsync_o, vsync_o, vde_o, red, green, blue}, 0);
        check("async_rst_cnt", {active_count, bad_count}, 0);
        check("async_rst_ready", 32'(bx.box_ready), 0);
        active.delete(); shadow.delete(); committed = 0; exp_bad = 0;
        repeat (2) @(negedge clk);
        reset = 1;
        repeat (2) @(negedge clk);
        check("post_rst_px", {7'h0, hsync_o, red, green, blue}, {7'h0, 1'b1, 24'h112233});
        pix("post_rst_model", 0, 0, 24'h112233, 1, model_px(0, 0, 24'h112233, 1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
